arb_8_32: RTL and testbench

- Word-atomic round-robin arbiter that shares the single 8-to-32 byte packer (conv8_32) among NUM_REQ byte-stream requesters.
- Grants one requester per 32-bit word and forwards exactly BYTES_PER_WORD bytes from that requester on the packer's in8/in_data8 inputs, so no word interleaves sources.
- Pads a word with zero bytes if the owning requester stalls too long.
- Runs in the packer's input clock domain.

---
 rtl/arb_8_32_pkg.sv | 21 ++
 rtl/arb_8_32_rr_pick.sv | 37 +++
 rtl/arb_8_32.sv | 172 +++++++++++++++++
 tb/tb_arb_8_32.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_8_32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_8_32_pkg
// Description : Shared constants for the 8-to-32 packer input arbiter:
//               arbiter state encodings and the byte/word geometry that is
//               common with the conv8_32 packer.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_8_32_pkg;

    // Arbiter state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_PAD  = 2'd2;

    // Word geometry defaults shared with conv8_32
    localparam int DEF_BYTES_PER_WORD = 4;
    localparam int DEF_DATA_W         = 8;

endpackage : arb_8_32_pkg
`default_nettype wire

// File: rtl/arb_8_32_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_8_32_rr_pick
// Description : Combinational round-robin selector. Returns the first set
//               request found when scanning from i_rr_ptr upward, wrapping
//               modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_8_32_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_any_req
);

    logic [ID_W-1:0] w_idx;

    // Scan from the pointer; the first hit wins, later hits are ignored.
    // NUM_REQ is a power of two, so the ID_W-bit add wraps naturally.
    always_comb begin
        o_winner  = '0;
        o_any_req = 1'b0;
        w_idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = i_rr_ptr + ID_W'(i);
            if (!o_any_req && i_req[w_idx]) begin
                o_winner  = w_idx;
                o_any_req = 1'b1;
            end
        end
    end

endmodule : arb_8_32_rr_pick
`default_nettype wire

// File: rtl/arb_8_32.sv
`default_nettype none
// ============================================================================
// Module      : arb_8_32
// Description : Word-atomic round-robin arbiter in front of the conv8_32
//               byte packer. One requester owns the packer for a full word;
//               a word whose owner stalls past TIMEOUT is completed with
//               zero bytes and flagged with pad_err.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_8_32
    import arb_8_32_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int TIMEOUT        = 16,
    parameter int ID_W           = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      in8,
    output logic [DATA_W-1:0]         in_data8,
    output logic [ID_W-1:0]           grant_id,
    output logic                      word_last,
    output logic                      pad_err,
    output logic                      busy
);

    // byte_cnt reaches BYTES_PER_WORD on the final byte, stall_cnt can reach
    // TIMEOUT on the cycle PAD is entered, so both get one spare code.
    localparam int c_cnt_w   = $clog2(BYTES_PER_WORD + 1);
    localparam int c_stall_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0]   c_last_byte = c_cnt_w'(BYTES_PER_WORD - 1);
    localparam logic [c_stall_w-1:0] c_stall_max = c_stall_w'(TIMEOUT - 1);

    logic [1:0]           r_state,     w_state_nxt;
    logic [ID_W-1:0]      r_rr_ptr,    w_rr_ptr_nxt;
    logic [c_cnt_w-1:0]   r_byte_cnt,  w_byte_cnt_nxt;
    logic [c_stall_w-1:0] r_stall_cnt, w_stall_cnt_nxt;
    logic [ID_W-1:0]      r_grant_id,  w_grant_id_nxt;
    logic                 r_in8,       w_in8_nxt;
    logic [DATA_W-1:0]    r_in_data8,  w_in_data8_nxt;
    logic                 r_word_last, w_word_last_nxt;
    logic                 r_pad_err,   w_pad_err_nxt;

    logic [ID_W-1:0]      w_winner;
    logic                 w_any_req;
    logic [DATA_W-1:0]    w_sel_data;
    logic                 w_xfer;

    arb_8_32_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_req     (req_valid),
        .i_rr_ptr  (r_rr_ptr),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

    // Only the current owner sees ready, and only while bytes are flowing.
    always_comb begin
        req_ready = '0;
        if (r_state == ST_XFER) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    // Mux the owner's byte lane out of the flat request data bus.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == r_grant_id) begin
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_xfer = req_valid[r_grant_id] & req_ready[r_grant_id];

    // Next-state and registered-output logic for IDLE / XFER / PAD.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_stall_cnt_nxt = r_stall_cnt;
        w_grant_id_nxt  = r_grant_id;
        w_in8_nxt       = 1'b0;
        w_in_data8_nxt  = '0;
        w_word_last_nxt = 1'b0;
        w_pad_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant_id_nxt  = w_winner;
                    w_byte_cnt_nxt  = '0;
                    w_stall_cnt_nxt = '0;
                    w_state_nxt     = ST_XFER;
                end
            end
            ST_XFER: begin
                // A byte on the last allowed stall cycle beats the timeout.
                if (w_xfer) begin
                    w_in8_nxt       = 1'b1;
                    w_in_data8_nxt  = w_sel_data;
                    w_byte_cnt_nxt  = r_byte_cnt + c_cnt_w'(1);
                    w_stall_cnt_nxt = '0;
                    if (r_byte_cnt == c_last_byte) begin
                        w_word_last_nxt = 1'b1;
                        w_rr_ptr_nxt    = r_grant_id + ID_W'(1);
                        w_state_nxt     = ST_IDLE;
                    end
                end else begin
                    w_stall_cnt_nxt = r_stall_cnt + c_stall_w'(1);
                    if (r_stall_cnt == c_stall_max) begin
                        w_state_nxt = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                w_in8_nxt      = 1'b1;
                w_byte_cnt_nxt = r_byte_cnt + c_cnt_w'(1);
                if (r_byte_cnt == c_last_byte) begin
                    w_word_last_nxt = 1'b1;
                    w_pad_err_nxt   = 1'b1;
                    w_rr_ptr_nxt    = r_grant_id + ID_W'(1);
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partial word silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_byte_cnt  <= '0;
            r_stall_cnt <= '0;
            r_grant_id  <= '0;
            r_in8       <= 1'b0;
            r_in_data8  <= '0;
            r_word_last <= 1'b0;
            r_pad_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_in8       <= w_in8_nxt;
            r_in_data8  <= w_in_data8_nxt;
            r_word_last <= w_word_last_nxt;
            r_pad_err   <= w_pad_err_nxt;
        end
    end

    assign in8       = r_in8;
    assign in_data8  = r_in_data8;
    assign grant_id  = r_grant_id;
    assign word_last = r_word_last;
    assign pad_err   = r_pad_err;
    assign busy      = (r_state != ST_IDLE);

endmodule : arb_8_32
`default_nettype wire

// File: tb/tb_arb_8_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_8_32
// Description : Self-checking bench for arb_8_32. Per-requester byte queues
//               drive a valid/ready source model; expected packer-side bytes
//               go into a scoreboard that a separate monitor drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_8_32;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    typedef struct {
        int         gap;
        logic [7:0] data;
    } item_t;

    typedef struct packed {
        logic [1:0] gid;
        logic [7:0] data;
        logic       last;
        logic       pad;
    } exp_t;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      in8;
    logic [DATA_W-1:0]         in_data8;
    logic [ID_W-1:0]           grant_id;
    logic                      word_last;
    logic                      pad_err;
    logic                      busy;

    item_t rq[NUM_REQ][$];
    exp_t  sb[$];
    int    wl_q[$];
    int    rem_gap[NUM_REQ];
    int    acc_cnt[NUM_REQ];
    int    cyc;
    int    n_vec;
    int    n_bad;
    logic  started;
    logic [NUM_REQ-1:0]        acc;
    logic [NUM_REQ-1:0]        valid_v;
    logic [NUM_REQ*DATA_W-1:0] data_v;

    arb_8_32 dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .in8       (in8),
        .in_data8  (in_data8),
        .grant_id  (grant_id),
        .word_last (word_last),
        .pad_err   (pad_err),
        .busy      (busy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index, advances on every rising edge
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic put(input int r, input int gap, input logic [7:0] d);
        item_t it;
        it.gap  = gap;
        it.data = d;
        rq[r].push_back(it);
    endtask

    task automatic put_word(input int r, input logic [31:0] w);
        for (int k = 0; k < 4; k++) put(r, 0, w[31-8*k -: 8]);
    endtask

    task automatic exp_byte(input logic [1:0] g, input logic [7:0] d, input logic l, input logic p);
        exp_t e;
        e.gid  = g;
        e.data = d;
        e.last = l;
        e.pad  = p;
        sb.push_back(e);
    endtask

    // Word expected MSB-first; a padded word flags pad_err on its last byte
    task automatic exp_word(input logic [1:0] g, input logic [31:0] w, input logic padded);
        for (int k = 0; k < 4; k++)
            exp_byte(g, w[31-8*k -: 8], (k == 3), padded && (k == 3));
    endtask

    task automatic chk_wl(input string name, input int k, input int exp);
        if (wl_q.size() > k) chk(name, wl_q[k], exp);
        else                 chk(name, 32'hFFFF_FFFF, exp);
    endtask

    // Requester model: sample handshake just before the edge, update after it
    initial begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem_gap[i] = -1;
            acc_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            #4;
            acc = req_valid & req_ready & {NUM_REQ{~reset}};
            @(posedge clk);
            #1;
            valid_v = '0;
            data_v  = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && rq[i].size() > 0) begin
                    void'(rq[i].pop_front());
                    acc_cnt[i]++;
                    rem_gap[i] = -1;
                end
                if (rq[i].size() > 0) begin
                    item_t it;
                    it = rq[i][0];
                    if (rem_gap[i] < 0) rem_gap[i] = it.gap;
                    if (rem_gap[i] > 0) begin
                        rem_gap[i]--;
                    end else begin
                        valid_v[i]             = 1'b1;
                        data_v[i*DATA_W +: 8] = it.data;
                    end
                end
            end
            req_valid = valid_v;
            req_data  = data_v;
        end
    end

    // Monitor: every packer byte is popped from the scoreboard and compared
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                if (in8) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got gid=%0d data=%02h last=%0b pad=%0b, expected none",
                                 grant_id, in_data8, word_last, pad_err);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        n_vec++;
                        if (grant_id !== e.gid || in_data8 !== e.data ||
                            word_last !== e.last || pad_err !== e.pad) begin
                            n_bad++;
                            $display("FAIL byte: got gid=%0d data=%02h last=%0b pad=%0b, expected gid=%0d data=%02h last=%0b pad=%0b",
                                     grant_id, in_data8, word_last, pad_err, e.gid, e.data, e.last, e.pad);
                        end
                    end
                    if (word_last) wl_q.push_back(cyc);
                end else begin
                    chk("flags_without_byte", {30'd0, word_last, pad_err}, 32'd0);
                end
            end
        end
    end

    // Call at a falling edge: reset spans one rising edge, then check outputs
    task automatic do_reset();
        #1;
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            rq[i].delete();
            rem_gap[i] = -1;
        end
        @(negedge clk);
        chk("rst_in8",       {31'd0, in8},       32'd0);
        chk("rst_in_data8",  {24'd0, in_data8},  32'd0);
        chk("rst_grant_id",  {30'd0, grant_id},  32'd0);
        chk("rst_word_last", {31'd0, word_last}, 32'd0);
        chk("rst_pad_err",   {31'd0, pad_err},   32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        #1;
        reset = 1'b0;
        wl_q.delete();
    endtask

    task automatic drain(input string name, input int budget);
        int  n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (sb.size() == 0) && !busy && (rq[0].size() == 0) && (rq[1].size() == 0) &&
                   (rq[2].size() == 0) && (rq[3].size() == 0);
        end
        if (!done) chk(name, 32'd0, 32'd1);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int n;
        int base;
        n_vec   = 0;
        n_bad   = 0;
        started = 1'b0;
        reset   = 1'b1;
        repeat (2) @(negedge clk);
        started = 1'b1;
        do_reset();

        // Single requester, back-to-back bytes
        put_word(2, 32'hA1A2A3A4);
        exp_word(2, 32'hA1A2A3A4, 1'b0);
        v = cyc + 1;
        drain("t1_drain", 100);
        chk_wl("t1_last_cycle", 0, v + 5);

        // Fairness: everyone valid, order 0,1,2,3,0 at 5 cycles per word
        do_reset();
        put_word(0, 32'h00010203);
        put_word(1, 32'h10111213);
        put_word(2, 32'h20212223);
        put_word(3, 32'h30313233);
        put_word(0, 32'h04050607);
        exp_word(0, 32'h00010203, 1'b0);
        exp_word(1, 32'h10111213, 1'b0);
        exp_word(2, 32'h20212223, 1'b0);
        exp_word(3, 32'h30313233, 1'b0);
        exp_word(0, 32'h04050607, 1'b0);
        v = cyc + 1;
        drain("t2_drain", 200);
        for (int k = 0; k < 5; k++) chk_wl("t2_word_cycle", k, v + 5 * (k + 1));

        // Mid-word stall of 5 cycles; req 2 waits meanwhile
        do_reset();
        put(1, 0, 8'h11);
        put(1, 0, 8'h22);
        put(1, 5, 8'h33);
        put(1, 0, 8'h44);
        put_word(2, 32'h2A2B2C2D);
        exp_word(1, 32'h11223344, 1'b0);
        exp_word(2, 32'h2A2B2C2D, 1'b0);
        v = cyc + 1;
        drain("t3_drain", 200);
        chk_wl("t3_stall_word_cycle", 0, v + 10);
        chk_wl("t3_next_word_cycle", 1, v + 15);

        // Timeout pad: req 3 sends one byte then goes quiet
        do_reset();
        put(3, 0, 8'h55);
        exp_word(3, 32'h55000000, 1'b1);
        v = cyc + 1;
        n = 0;
        while (!(busy && grant_id == 2'd3) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_grant_req3", {30'd0, grant_id}, 32'd3);
        #1;
        put_word(0, 32'h60616263);
        put_word(2, 32'h70717273);
        exp_word(0, 32'h60616263, 1'b0);
        exp_word(2, 32'h70717273, 1'b0);
        drain("t4_drain", 300);
        chk_wl("t4_pad_word_cycle", 0, v + 21);
        chk_wl("t4_req0_word_cycle", 1, v + 26);
        chk_wl("t4_req2_word_cycle", 2, v + 31);

        // Boundary: byte arrives on stall cycle TIMEOUT-1, no padding
        do_reset();
        put(1, 0, 8'hB0);
        put(1, 15, 8'hB1);
        put(1, 0, 8'hB2);
        put(1, 0, 8'hB3);
        exp_word(1, 32'hB0B1B2B3, 1'b0);
        v = cyc + 1;
        drain("t5_drain", 200);
        chk_wl("t5_boundary_word_cycle", 0, v + 20);

        // Reset mid-word (rr_ptr is 2 here), then req 0 must win over 1 and 3
        #1;
        base = acc_cnt[0];
        put_word(0, 32'h01020304);
        exp_byte(2'd0, 8'h01, 1'b0, 1'b0);
        exp_byte(2'd0, 8'h02, 1'b0, 1'b0);
        n = 0;
        while (acc_cnt[0] < base + 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_two_bytes_accepted", acc_cnt[0] - base, 32'd2);
        do_reset();
        put_word(0, 32'h81828384);
        put_word(1, 32'h91929394);
        put_word(3, 32'hB1B2B3B4);
        exp_word(0, 32'h81828384, 1'b0);
        exp_word(1, 32'h91929394, 1'b0);
        exp_word(3, 32'hB1B2B3B4, 1'b0);
        v = cyc + 1;
        drain("t6_drain", 200);
        chk_wl("t6_first_word_cycle", 0, v + 5);
        chk("t6_scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_arb_8_32
`default_nettype wire
